resonator_dds_divseq: RTL

RESONATOR_DDS_DIVSEQ -- requirements
Module: resonator_dds_divseq

---
 rtl/resonator_dds_divseq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/resonator_dds_divseq.sv
// Sequential signed divider: 33-bit dividend by 16-bit divisor, restoring
// algorithm one bit per enabled cycle, with saturated 17-bit quotient,
// dividend-signed remainder and divide-by-zero reporting.
module resonator_dds_divseq (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [32:0] din0,
    input  logic [15:0] din1,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [16:0] quot,
    output logic [15:0] rem,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    // Dividend magnitude; quotient bits shift in from the LSB as dividend
    // bits leave from the MSB, so after 33 steps it holds |quotient|.
    logic [32:0] dvd_q;
    logic [15:0] dvs_mag;
    logic [16:0] part_rem;
    logic [5:0]  step_cnt;
    logic        sign_dvd;
    logic        sign_dvs;

    logic        accept;
    logic        consume;
    logic        last_step;
    logic [32:0] dvd_mag_in;
    logic [15:0] dvs_mag_in;
    logic [17:0] trial;
    logic        trial_ge;
    logic [16:0] part_rem_nxt;
    logic        q_neg;
    logic        div_zero;
    logic [16:0] quot_fix;
    logic [15:0] rem_fix;
    logic        ovf_fix;

    // Handshake qualifiers and operand magnitudes (two's-complement negate
    // keeps -2^32 and -32768 as their full unsigned magnitudes).
    always_comb begin
        accept     = ce & din_valid & din_ready;
        consume    = ce & dout_valid & dout_ready;
        last_step  = (step_cnt == 6'd32);
        dvd_mag_in = din0[32] ? (~din0 + 33'd1) : din0;
        dvs_mag_in = din1[15] ? (~din1 + 16'd1) : din1;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    always_comb begin
        trial        = {part_rem, dvd_q[32]};
        trial_ge     = (trial >= {2'b00, dvs_mag});
        part_rem_nxt = trial_ge ? (trial[16:0] - {1'b0, dvs_mag}) : trial[16:0];
    end

    // Sign application and saturation of the finished magnitudes.
    always_comb begin
        q_neg    = sign_dvd ^ sign_dvs;
        div_zero = (dvs_mag == 16'd0);
        quot_fix = '0;
        rem_fix  = '0;
        ovf_fix  = 1'b0;
        if (div_zero) begin
            quot_fix = sign_dvd ? 17'h10000 : 17'h0FFFF;
        end else begin
            if (q_neg) begin
                if (dvd_q > 33'd65536) begin
                    quot_fix = 17'h10000;
                    ovf_fix  = 1'b1;
                end else begin
                    quot_fix = ~dvd_q[16:0] + 17'd1;
                end
            end else begin
                if (dvd_q > 33'd65535) begin
                    quot_fix = 17'h0FFFF;
                    ovf_fix  = 1'b1;
                end else begin
                    quot_fix = dvd_q[16:0];
                end
            end
            rem_fix = sign_dvd ? (16'd0 - part_rem[15:0]) : part_rem[15:0];
        end
    end

    // State register; reset overrides ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; transitions only on enabled cycles.
    always_comb begin
        state_nxt  = state;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (accept) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (ce && last_step) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                if (ce) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                dout_valid = 1'b1;
                if (consume) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q    <= '0;
            dvs_mag  <= '0;
            part_rem <= '0;
            step_cnt <= '0;
            sign_dvd <= 1'b0;
            sign_dvs <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_q    <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        part_rem <= '0;
                        step_cnt <= '0;
                        sign_dvd <= din0[32];
                        sign_dvs <= din1[15];
                    end
                end
                CALC: begin
                    dvd_q    <= {dvd_q[31:0], trial_ge};
                    part_rem <= part_rem_nxt;
                    step_cnt <= step_cnt + 6'd1;
                end
                FIX: begin
                    quot <= quot_fix;
                    rem  <= rem_fix;
                    ovf  <= ovf_fix;
                    dz   <= div_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
